// File: rtl/dmem_port_if.sv
// Signal bundle around dmem_port_arbiter: MEM-stage load port, store-buffer drain port,
// tagged load response and the single-ported data-memory req/gnt/rvalid bus.
interface dmem_port_if #(
  parameter int TAG_W = 5
);
  logic             ld_valid_i;
  logic             ld_ready_o;
  logic [31:0]      ld_addr_i;
  logic [TAG_W-1:0] ld_tag_i;
  logic             st_valid_i;
  logic             st_ready_o;
  logic [31:0]      st_addr_i;
  logic [31:0]      st_data_i;
  logic             flush_i;
  logic             ld_rsp_valid_o;
  logic [31:0]      ld_rsp_data_o;
  logic [TAG_W-1:0] ld_rsp_tag_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic             mem_gnt_i;
  logic             mem_rvalid_i;
  logic [31:0]      mem_rdata_i;

  // Arbiter side
  modport master (
    input  ld_valid_i, ld_addr_i, ld_tag_i, st_valid_i, st_addr_i, st_data_i, flush_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ld_ready_o, st_ready_o, ld_rsp_valid_o, ld_rsp_data_o, ld_rsp_tag_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Pipeline / store buffer / memory side
  modport slave (
    output ld_valid_i, ld_addr_i, ld_tag_i, st_valid_i, st_addr_i, st_data_i, flush_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ld_ready_o, st_ready_o, ld_rsp_valid_o, ld_rsp_data_o, ld_rsp_tag_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates MEM-stage loads against store-buffer drains onto a single data-memory port,
// one transaction at a time, with a starvation bound so committed stores always drain.
module dmem_port_arbiter #(
  parameter int TAG_W        = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  dmem_port_if.master bus
);
  localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] starve_reg, starve_next;
  logic             kill_reg, kill_next;
  logic             we_reg, we_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [31:0]      rsp_data_reg, rsp_data_next;
  logic [TAG_W-1:0] rsp_tag_reg, rsp_tag_next;
  logic             ld_elig, ld_win, st_win;

  always_comb begin
    ld_elig        = bus.ld_valid_i && !bus.flush_i;
    ld_win         = 1'b0;
    st_win         = 1'b0;
    state_next     = state_reg;
    starve_next    = starve_reg;
    kill_next      = kill_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    tag_next       = tag_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;
    rsp_tag_next   = rsp_tag_reg;

    // Readies are gated by reset so they read 0 while reset is asserted.
    if (rstn_i && state_reg == IDLE) begin
      if (ld_elig && bus.st_valid_i) begin
        st_win = (starve_reg == LIMIT);
        ld_win = !st_win;
      end else begin
        ld_win = ld_elig;
        st_win = bus.st_valid_i;
      end
    end

    case (state_reg)
      IDLE: begin
        kill_next = 1'b0;
        if (ld_win) begin
          state_next = REQ;
          we_next    = 1'b0;
          addr_next  = bus.ld_addr_i;
          wdata_next = 32'h0;
          tag_next   = bus.ld_tag_i;
          if (bus.st_valid_i && starve_reg != LIMIT)
            starve_next = starve_reg + 1'b1;
        end else if (st_win) begin
          state_next  = REQ;
          we_next     = 1'b1;
          addr_next   = bus.st_addr_i;
          wdata_next  = bus.st_data_i;
          tag_next    = '0;
          starve_next = '0;
        end
      end
      REQ: begin
        if (bus.flush_i && !we_reg)
          kill_next = 1'b1;
        if (bus.mem_gnt_i) begin
          state_next = we_reg ? IDLE : RSP;
          if (we_reg)
            kill_next = 1'b0;
        end
      end
      RSP: begin
        if (bus.flush_i)
          kill_next = 1'b1;
        if (bus.mem_rvalid_i) begin
          state_next = IDLE;
          kill_next  = 1'b0;
          // A flush arriving together with the read data still kills the response.
          if (!kill_reg && !bus.flush_i) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = bus.mem_rdata_i;
            rsp_tag_next   = tag_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= IDLE;
      starve_reg    <= '0;
      kill_reg      <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      tag_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_tag_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      kill_reg      <= kill_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      tag_reg       <= tag_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_tag_reg   <= rsp_tag_next;
    end
  end

  assign bus.ld_ready_o     = ld_win;
  assign bus.st_ready_o     = st_win;
  assign bus.mem_req_o      = (state_reg == REQ);
  assign bus.mem_we_o       = we_reg;
  assign bus.mem_addr_o     = addr_reg;
  assign bus.mem_wdata_o    = wdata_reg;
  assign bus.ld_rsp_valid_o = rsp_valid_reg;
  assign bus.ld_rsp_data_o  = rsp_data_reg;
  assign bus.ld_rsp_tag_o   = rsp_tag_reg;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model (arbitration rule, memory contents, responses).
module tb_dmem_port_arbiter;
  localparam int TAG_W = 5;
  localparam int LIMIT = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_port_if #(.TAG_W(TAG_W)) bus ();
  dmem_port_arbiter #(.TAG_W(TAG_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int txn_no     = 0;

  // Reference model state
  int               model_starve = 0;
  logic [31:0]      mem_model [logic [31:0]];
  logic             exp_rsp_valid = 1'b0;
  logic [31:0]      exp_rsp_data  = 32'h0;
  logic [TAG_W-1:0] exp_rsp_tag   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string where);
    chk({where, ".rsp_valid"}, 64'(bus.ld_rsp_valid_o), 64'(exp_rsp_valid));
    chk({where, ".rsp_data"},  64'(bus.ld_rsp_data_o),  64'(exp_rsp_data));
    chk({where, ".rsp_tag"},   64'(bus.ld_rsp_tag_o),   64'(exp_rsp_tag));
  endtask

  task automatic chk_quiet(input string where);
    chk({where, ".ld_ready"}, 64'(bus.ld_ready_o), 64'd0);
    chk({where, ".st_ready"}, 64'(bus.st_ready_o), 64'd0);
    chk_rsp(where);
  endtask

  // Entered at posedge+1 of a cycle where the DUT should be idle; returns at posedge+1
  // of the next idle cycle. flush_at counts REQ/RSP cycles from 0.
  task automatic run_txn(input logic ld_v, input logic st_v, input logic fl_idle,
                         input logic [31:0] la, input logic [TAG_W-1:0] lt,
                         input logic [31:0] sa, input logic [31:0] sd,
                         input int gnt_dly, input int rv_dly, input int flush_at,
                         output byte won);
    logic        exp_ld, exp_st, killed;
    logic [31:0] rd;
    int          k;
    bus.ld_valid_i = ld_v; bus.ld_addr_i = la; bus.ld_tag_i = lt;
    bus.st_valid_i = st_v; bus.st_addr_i = sa; bus.st_data_i = sd;
    bus.flush_i    = fl_idle;
    bus.mem_gnt_i  = 1'b0; bus.mem_rvalid_i = 1'b0;
    exp_ld = ld_v && !fl_idle && !(st_v && model_starve == LIMIT);
    exp_st = st_v && !exp_ld;
    @(negedge clk);
    chk("idle.ld_ready", 64'(bus.ld_ready_o), 64'(exp_ld));
    chk("idle.st_ready", 64'(bus.st_ready_o), 64'(exp_st));
    chk("idle.one_ready", 64'(bus.ld_ready_o && bus.st_ready_o), 64'd0);
    chk("idle.mem_req", 64'(bus.mem_req_o), 64'd0);
    chk_rsp("idle");
    won = bus.ld_ready_o ? "L" : (bus.st_ready_o ? "S" : "N");
    exp_rsp_valid = 1'b0;
    if (exp_ld && st_v && model_starve < LIMIT) model_starve++;
    if (exp_st) model_starve = 0;
    txn_no++;
    $display("txn %0d: %s ld_v=%0d st_v=%0d flush=%0d ld_addr=%h tag=%0d st_addr=%h st_data=%h gnt_dly=%0d rv_dly=%0d flush_at=%0d",
             txn_no, exp_ld ? "LOAD" : (exp_st ? "STORE" : "NONE"), ld_v, st_v, fl_idle,
             la, lt, sa, sd, gnt_dly, rv_dly, flush_at);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    if (!exp_ld && !exp_st) return;

    killed = 1'b0;
    k = 0;
    for (int i = 0; i <= gnt_dly; i++) begin
      bus.mem_gnt_i    = (i == gnt_dly);
      bus.mem_rvalid_i = 1'($urandom_range(0, 1));
      bus.flush_i      = (k == flush_at);
      if (exp_ld && bus.flush_i) killed = 1'b1;
      @(negedge clk);
      chk("req.mem_req",   64'(bus.mem_req_o),   64'd1);
      chk("req.mem_we",    64'(bus.mem_we_o),    64'(!exp_ld));
      chk("req.mem_addr",  64'(bus.mem_addr_o),  64'(exp_ld ? la : sa));
      chk("req.mem_wdata", 64'(bus.mem_wdata_o), 64'(exp_ld ? 32'h0 : sd));
      chk_quiet("req");
      @(posedge clk); #1;
      k++;
    end
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.flush_i = 1'b0;
    if (!exp_ld) begin
      mem_model[sa] = sd;
      return;
    end

    rd = mem_model.exists(la) ? mem_model[la] : ~la;
    for (int j = 0; j <= rv_dly; j++) begin
      bus.mem_rvalid_i = (j == rv_dly);
      bus.mem_rdata_i  = (j == rv_dly) ? rd : $urandom;
      bus.mem_gnt_i    = 1'($urandom_range(0, 1));
      bus.flush_i      = (k == flush_at);
      if (bus.flush_i) killed = 1'b1;
      @(negedge clk);
      chk("rsp.mem_req", 64'(bus.mem_req_o), 64'd0);
      chk_quiet("rsp");
      @(posedge clk); #1;
      k++;
    end
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.flush_i = 1'b0;
    if (!killed) begin
      exp_rsp_valid = 1'b1;
      exp_rsp_data  = rd;
      exp_rsp_tag   = lt;
    end
  endtask

  task automatic idle_cycle();
    byte w;
    run_txn(1'b0, 1'b0, 1'b0, 32'h0, '0, 32'h0, 32'h0, 0, 0, -1, w);
  endtask

  initial begin
    byte   w;
    string exp_order;
    int    ld_r, st_r, fl_r, gd, rv, fa;
    bus.ld_valid_i = 1'b0; bus.ld_addr_i = '0; bus.ld_tag_i = '0;
    bus.st_valid_i = 1'b0; bus.st_addr_i = '0; bus.st_data_i = '0;
    bus.flush_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // Reset state
    #1;
    chk("rst.mem_req",   64'(bus.mem_req_o),   64'd0);
    chk("rst.mem_we",    64'(bus.mem_we_o),    64'd0);
    chk("rst.mem_addr",  64'(bus.mem_addr_o),  64'd0);
    chk("rst.mem_wdata", 64'(bus.mem_wdata_o), 64'd0);
    chk_quiet("rst");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single store, gnt immediate
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, '0, 32'h100, 32'hDEADBEEF, 0, 0, -1, w);
    // Load with gnt delayed 2 and rvalid 3 cycles after gnt
    mem_model[32'h40] = 32'h12345678;
    run_txn(1'b1, 1'b0, 1'b0, 32'h40, 5'd3, 32'h0, 32'h0, 2, 2, -1, w);
    idle_cycle();

    // Both requesters held: load wins until the starve bound forces a store
    exp_order = "LLLLSLLLLS";
    for (int i = 0; i < 10; i++) begin
      run_txn(1'b1, 1'b1, 1'b0, 32'h80 + 32'(i * 4), 5'(i), 32'h400 + 32'(i * 4),
              32'hA000_0000 + 32'(i), 0, 0, -1, w);
      chk($sformatf("order[%0d]", i), 64'(w), 64'(exp_order[i]));
    end
    idle_cycle();

    // Flush during RSP kills the response; the next load returns normally
    run_txn(1'b1, 1'b0, 1'b0, 32'h40, 5'd5, 32'h0, 32'h0, 0, 1, 1, w);
    run_txn(1'b1, 1'b0, 1'b0, 32'h44, 5'd7, 32'h0, 32'h0, 0, 0, -1, w);
    idle_cycle();

    // Flush in IDLE blocks the load only
    run_txn(1'b1, 1'b1, 1'b1, 32'h48, 5'd9, 32'h500, 32'h55AA55AA, 0, 0, -1, w);
    chk("flush_idle.winner", 64'(w), 64'("S"));
    run_txn(1'b1, 1'b1, 1'b0, 32'h48, 5'd9, 32'h504, 32'h0, 1, 1, -1, w);
    chk("flush_idle.later", 64'(w), 64'("L"));
    idle_cycle();

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      ld_r = int'($urandom_range(0, 3));
      st_r = int'($urandom_range(0, 1));
      fl_r = int'($urandom_range(0, 3));
      gd   = int'($urandom_range(0, 3));
      rv   = int'($urandom_range(0, 3));
      fa   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_txn(ld_r != 0, st_r != 0, fl_r == 0,
              32'h1000 + 32'($urandom_range(0, 7) * 4), 5'($urandom),
              32'h1000 + 32'($urandom_range(0, 7) * 4), $urandom, gd, rv, fa, w);
    end
    idle_cycle();

    // Asynchronous reset while a store sits in REQ
    bus.st_valid_i = 1'b1; bus.st_addr_i = 32'h200; bus.st_data_i = 32'hCAFEF00D;
    bus.ld_valid_i = 1'b0;
    @(negedge clk);
    chk("arst.accept", 64'(bus.st_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.ld_valid_i = 1'b1;
    @(negedge clk);
    chk("arst.req_before", 64'(bus.mem_req_o), 64'd1);
    #2;
    rstn = 1'b0;
    model_starve = 0;
    exp_rsp_valid = 1'b0; exp_rsp_data = 32'h0; exp_rsp_tag = '0;
    #1;
    chk("arst.mem_req", 64'(bus.mem_req_o), 64'd0);
    chk_quiet("arst");
    @(posedge clk); #1;
    rstn = 1'b1;
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, '0, 32'h300, 32'h0BADF00D, 0, 0, -1, w);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
